control_fsm: RTL
================

Name: control_fsm

Overview:
- Multi-cycle, handshaked successor to the single-cycle opcode decoder. Accepts one instruction opcode per valid/ready handshake, decodes it and drives exactly one of the memwrite/memread/branch/aluen strobes.
- Memory operations hold their strobe until the memory side answers, with a timeout.
- Sits between the instruction fetch stage and the datapath/memory interface.

Parameters:
- OPW, 6, opcode width in bits.
- OP_LOAD, 6'b010001, opcode that drives memread.
- OP_STORE, 6'b010000, opcode that drives memwrite.
- OP_BRANCH, 6'b100000, opcode that drives branch.
- ALU_DEFAULT, 1, mode select:
  - 1: any other opcode is treated as an ALU op.
  - 0: any other opcode is illegal and raises error.
- MEM_TIMEOUT, 15, maximum number of MEM-state cycles without mem_ready before abort. Legal range is 1..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- instr_valid  input  1  opcode is presented.
- opcode  input  OPW  instruction opcode, sampled on handshake.
- instr_ready  output  1  FSM is able to accept an opcode (IDLE state).
- mem_ready  input  1  memory has completed the current read/write.
- err_clr  input  1  clears the sticky error flag.
- memwrite  output  1  store strobe.
- memread  output  1  load strobe.
- branch  output  1  branch strobe.
- aluen  output  1  ALU enable strobe.
- busy  output  1  high in any state other than IDLE.
- error  output  1  sticky flag for timeout or illegal opcode.

Behaviour:
- All outputs are registered; only instr_ready and busy are decoded from the state register.
- Reset: reset==0 at a rising edge forces the following, with no partial completion:
  - state=IDLE; opcode register and timeout counter cleared.
  - memwrite, memread, branch, aluen and error = 0.
  - Consequently instr_ready=1 and busy=0.
- Reset mid-operation (e.g. while in MEM) aborts immediately: strobes drop on the next edge.
- States: IDLE, DECODE, EXEC, MEM.
- IDLE:
  - instr_ready=1.
  - instr_valid=1 at an edge captures opcode and moves to DECODE (handshake cycle = cycle 0).
- DECODE (cycle 1):
  - Classifies the captured opcode.
  - LOAD or STORE: go to MEM, registering memread or memwrite =1 for cycle 2, and clear the counter.
  - BRANCH: go to EXEC with branch=1.
  - Other opcode with ALU_DEFAULT=1: go to EXEC with aluen=1.
  - Other opcode with ALU_DEFAULT=0: set error=1, go to IDLE, assert no strobe.
- EXEC (cycle 2): the strobe is high for exactly this one cycle; it deasserts and the FSM returns to IDLE (instr_ready=1 in cycle 3).
- MEM:
  - The strobe stays high; the counter increments every cycle.
  - mem_ready=1: the strobe is still high in that cycle; strobe drops and the FSM goes to IDLE next edge.
  - Counter reaches MEM_TIMEOUT with mem_ready=0: strobe drops, error is set, FSM goes to IDLE.
  - Counter reaching MEM_TIMEOUT and mem_ready=1 in the same cycle counts as a normal completion (mem_ready wins; no error).
  - mem_ready is ignored outside MEM.
- Strobe exclusivity: at most one of memwrite/memread/branch/aluen is ever 1.
- Error flag:
  - Sticky until err_clr=1 or reset.
  - If an error set event and err_clr occur in the same cycle, set wins.
  - error does not block new instructions.
- Back-to-back issue: no new opcode is accepted until the FSM is back in IDLE; instr_valid is ignored while busy.
- Minimum issue interval is 3 cycles for ALU/branch ops.
- Counter width is 8 bits and does not wrap; it saturates at MEM_TIMEOUT.

Test Plan:
- Reset: hold reset=0 for 2 cycles with instr_valid=1 -> all strobes 0, error=0, instr_ready=1. Release; the first accepted opcode is the one presented after release.
- ALU and branch path: opcode=6'b000011 accepted at cycle 0 -> aluen=1 only in cycle 2, instr_ready=1 in cycle 3. Repeat with 6'b100000 -> branch=1 only in cycle 2.
- Load with wait: opcode=6'b010001, mem_ready pulsed at MEM cycle 4 -> memread high for 4 cycles (cycles 2-5), then 0; error=0.
- Store timeout: opcode=6'b010000, mem_ready held 0, MEM_TIMEOUT=15 -> memwrite high 15 cycles, then 0; error=1 and stays 1 until err_clr=1.
- Timeout tie and abort: mem_ready=1 in exactly the 15th MEM cycle -> no error. Separately, reset=0 asserted in MEM cycle 3 -> memread=0 and state IDLE next edge.
- Illegal mode: ALU_DEFAULT=0, opcode=6'b111111 -> no strobe, error=1 at cycle 2, instr_ready=1 at cycle 2. With instr_valid held high, opcode=6'b010001 is then accepted at cycle 2.

Source files
------------

// File: rtl/control_fsm_if.sv
// Handshake and strobe bundle between the fetch/memory side and control_fsm.
interface control_fsm_if #(
    parameter int unsigned OPW = 6
);
    logic           instr_valid;
    logic [OPW-1:0] opcode;
    logic           instr_ready;
    logic           mem_ready;
    logic           err_clr;
    logic           memwrite;
    logic           memread;
    logic           branch;
    logic           aluen;
    logic           busy;
    logic           error;

    // Fetch stage / memory side: presents opcodes, answers memory ops.
    modport master (
        output instr_valid, opcode, mem_ready, err_clr,
        input  instr_ready, memwrite, memread, branch, aluen, busy, error
    );

    // Control FSM side.
    modport slave (
        input  instr_valid, opcode, mem_ready, err_clr,
        output instr_ready, memwrite, memread, branch, aluen, busy, error
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle handshaked opcode decoder: one opcode per handshake, one strobe per op.
// Memory strobes are held until mem_ready or until the MEM-cycle budget runs out.
module control_fsm #(
    parameter int unsigned    OPW         = 6,
    parameter logic [OPW-1:0] OP_LOAD     = 6'b010001,
    parameter logic [OPW-1:0] OP_STORE    = 6'b010000,
    parameter logic [OPW-1:0] OP_BRANCH   = 6'b100000,
    parameter bit             ALU_DEFAULT = 1'b1,
    parameter int unsigned    MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StMem} state_e;

    localparam logic [7:0] TmoVal = 8'(MEM_TIMEOUT);

    state_e         state_q, state_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           memwrite_q, memwrite_d;
    logic           memread_q, memread_d;
    logic           branch_q, branch_d;
    logic           aluen_q, aluen_d;
    logic           error_q, error_d;
    logic           err_set;
    logic           is_mem_op;

    assign is_mem_op = (opcode_q == OP_LOAD) || (opcode_q == OP_STORE);

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            opcode_q   <= '0;
            cnt_q      <= '0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            branch_q   <= 1'b0;
            aluen_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            cnt_q      <= cnt_d;
            memwrite_q <= memwrite_d;
            memread_q  <= memread_d;
            branch_q   <= branch_d;
            aluen_q    <= aluen_d;
            error_q    <= error_d;
        end
    end

    // Next state, opcode capture, MEM-cycle counter and error-set events.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.instr_valid) begin
                    opcode_d = bus.opcode;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (is_mem_op) begin
                    state_d = StMem;
                    cnt_d   = '0;
                end else if (opcode_q == OP_BRANCH || ALU_DEFAULT) begin
                    state_d = StExec;
                end else begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
            StExec: begin
                state_d = StIdle;
            end
            StMem: begin
                // Counter saturates at the limit rather than wrapping.
                cnt_d = (cnt_q == TmoVal) ? cnt_q : cnt_q + 8'd1;
                if (bus.mem_ready) begin
                    state_d = StIdle;
                end else if (cnt_q + 8'd1 >= TmoVal) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Next values of the registered strobes, derived from the state being entered.
    always_comb begin
        memwrite_d = (state_d == StMem)  && (opcode_q == OP_STORE);
        memread_d  = (state_d == StMem)  && (opcode_q == OP_LOAD);
        branch_d   = (state_d == StExec) && (opcode_q == OP_BRANCH);
        aluen_d    = (state_d == StExec) && (opcode_q != OP_BRANCH);
        // A new error outranks a simultaneous clear.
        error_d    = err_set | (error_q & ~bus.err_clr);
    end

    assign bus.instr_ready = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.memwrite    = memwrite_q;
    assign bus.memread     = memread_q;
    assign bus.branch      = branch_q;
    assign bus.aluen       = aluen_q;
    assign bus.error       = error_q;

endmodule
